// File: rtl/delay_stream_ctrl.sv
// Valid/ready wrapper around an external fixed-latency delay line.
// Tracks per-stage valid bits, stalls on head backpressure and supports draining via flush.
module delay_stream_ctrl #(
   parameter int CYCLES = 4,
   parameter int WIDTH  = 8
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          in_valid,
   output logic                          in_ready,
   input  logic [WIDTH-1:0]              in_data,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic [WIDTH-1:0]              out_data,
   output logic                          delay_en,
   output logic [WIDTH-1:0]              delay_in,
   input  logic [WIDTH-1:0]              delay_out,
   input  logic                          flush_req,
   output logic                          flush_done,
   output logic                          busy,
   output logic [$clog2(CYCLES+1)-1:0]   occupancy,
   output logic [15:0]                   accept_count,
   output logic [15:0]                   emit_count
);

   // state | meaning
   // RUN   | normal streaming, upstream accepted when the pipe advances
   // FLUSH | upstream blocked, in-flight items drain until the pipe is empty

   localparam int OW = $clog2(CYCLES+1);

   typedef enum logic {RUN = 1'b0, FLUSH = 1'b1} state_t;

   state_t            state_q, state_d;
   logic [CYCLES-1:0] v_q, v_d, v_shift;
   logic [OW-1:0]     occ_q, occ_d;
   logic [15:0]       acc_q, acc_d;
   logic [15:0]       emit_q, emit_d;
   logic              flush_done_q, flush_done_d;
   logic              accept;
   logic              emit;

   assign out_valid = v_q[CYCLES-1];
   assign delay_en  = !out_valid || out_ready;
   assign in_ready  = delay_en && (state_q == RUN);
   assign accept    = in_valid && in_ready;
   assign emit      = out_valid && out_ready;

   assign out_data  = delay_out;
   assign delay_in  = in_data;

   generate
      if (CYCLES == 1) begin : g_single
         assign v_shift = accept;
      end else begin : g_multi
         assign v_shift = {v_q[CYCLES-2:0], accept};
      end
   endgenerate

   always_comb begin
      v_d          = delay_en ? v_shift : v_q;
      occ_d        = occ_q;
      acc_d        = acc_q + {15'd0, accept};
      emit_d       = emit_q + {15'd0, emit};
      state_d      = state_q;
      flush_done_d = 1'b0;

      if (accept && !emit) begin
         occ_d = occ_q + OW'(1);
      end else if (emit && !accept) begin
         occ_d = occ_q - OW'(1);
      end

      case (state_q)
         RUN: begin
            if (flush_req) begin
               state_d = FLUSH;
            end
         end
         FLUSH: begin
            // occupancy is the pre-edge count, so the last emit must land first
            if ((occ_q == '0) && !emit) begin
               state_d      = RUN;
               flush_done_d = 1'b1;
            end
         end
         default: state_d = RUN;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= RUN;
         v_q          <= '0;
         occ_q        <= '0;
         acc_q        <= '0;
         emit_q       <= '0;
         flush_done_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         v_q          <= v_d;
         occ_q        <= occ_d;
         acc_q        <= acc_d;
         emit_q       <= emit_d;
         flush_done_q <= flush_done_d;
      end
   end

   assign busy         = (state_q == FLUSH);
   assign flush_done   = flush_done_q;
   assign occupancy    = occ_q;
   assign accept_count = acc_q;
   assign emit_count   = emit_q;

endmodule

// File: tb/tb_delay_stream_ctrl.sv
// Directed bench for delay_stream_ctrl with a behavioural delay line and a data scoreboard.
module tb_delay_stream_ctrl;

   localparam int C = 4;
   localparam int W = 8;
   localparam logic [W-1:0] RST_VAL = 8'h5A;

   logic          clk = 1'b0;
   logic          rst;
   logic          in_valid, in_ready;
   logic [W-1:0]  in_data;
   logic          out_valid, out_ready;
   logic [W-1:0]  out_data;
   logic          delay_en;
   logic [W-1:0]  delay_in, delay_out;
   logic          flush_req, flush_done, busy;
   logic [$clog2(C+1)-1:0] occupancy;
   logic [15:0]   accept_count, emit_count;

   delay_stream_ctrl #(.CYCLES(C), .WIDTH(W)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .delay_en(delay_en), .delay_in(delay_in), .delay_out(delay_out),
      .flush_req(flush_req), .flush_done(flush_done), .busy(busy),
      .occupancy(occupancy), .accept_count(accept_count), .emit_count(emit_count)
   );

   always #5 clk = ~clk;

   // behavioural model of the attached delay instance
   logic [W-1:0] dl_q [C];
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < C; i++) dl_q[i] <= RST_VAL;
      end else if (delay_en) begin
         dl_q[0] <= delay_in;
         for (int i = 1; i < C; i++) dl_q[i] <= dl_q[i-1];
      end
   end
   assign delay_out = dl_q[C-1];

   int checks = 0;
   int errors = 0;

   logic [C-1:0] mv;
   logic         m_flush;
   logic         m_fd;
   int           m_occ;
   logic [15:0]  m_acc_cnt, m_emit_cnt;
   logic [W-1:0] sb [$];

   int call_idx = 0;
   int first_acc = -1;
   int first_ov = -1;
   int max_occ = 0;
   int fd_pulses = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_clear();
      mv = '0; m_flush = 1'b0; m_fd = 1'b0; m_occ = 0;
      m_acc_cnt = '0; m_emit_cnt = '0;
      sb.delete();
   endtask

   // called at a negedge; returns at the next negedge
   task automatic cycle(input logic iv, input logic [W-1:0] id, input logic ordy, input logic fr);
      logic m_ov, m_en, m_ir, m_a, m_e;
      int   occ_old;
      in_valid = iv; in_data = id; out_ready = ordy; flush_req = fr;
      #1;
      m_ov = mv[C-1];
      m_en = !m_ov || ordy;
      m_ir = m_en && !m_flush;
      m_a  = iv && m_ir;
      m_e  = m_ov && ordy;
      chk("out_valid", out_valid, m_ov);
      chk("delay_en", delay_en, m_en);
      chk("in_ready", in_ready, m_ir);
      chk("delay_in", delay_in, id);
      if (m_ov) begin
         if (sb.size() > 0) chk("out_data", out_data, sb[0]);
         else chk("scoreboard_nonempty", 32'd0, 32'd1);
      end
      if (out_valid && first_ov < 0) first_ov = call_idx;
      if (m_a && first_acc < 0) first_acc = call_idx;
      if (m_a) sb.push_back(id);
      if (m_e && sb.size() > 0) void'(sb.pop_front());
      @(posedge clk);
      occ_old = m_occ;
      if (!m_flush) begin
         m_fd = 1'b0;
         if (fr) m_flush = 1'b1;
      end else if (occ_old == 0 && !m_e) begin
         m_flush = 1'b0;
         m_fd    = 1'b1;
      end else begin
         m_fd = 1'b0;
      end
      if (m_en) mv = {mv[C-2:0], m_a};
      m_occ = m_occ + int'(m_a) - int'(m_e);
      m_acc_cnt  = m_acc_cnt + 16'(m_a);
      m_emit_cnt = m_emit_cnt + 16'(m_e);
      @(negedge clk);
      chk("occupancy", occupancy, m_occ);
      chk("accept_count", accept_count, m_acc_cnt);
      chk("emit_count", emit_count, m_emit_cnt);
      chk("busy", busy, m_flush);
      chk("flush_done", flush_done, m_fd);
      if (int'(occupancy) > max_occ) max_occ = int'(occupancy);
      if (flush_done) fd_pulses++;
      call_idx++;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      logic done;
      rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b1; flush_req = 1'b0;
      model_clear();
      #2;
      chk("rst_in_ready", in_ready, 1);
      chk("rst_delay_en", delay_en, 1);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_occupancy", occupancy, 0);
      chk("rst_accept_count", accept_count, 0);
      chk("rst_emit_count", emit_count, 0);
      chk("rst_busy", busy, 0);
      chk("rst_flush_done", flush_done, 0);
      chk("rst_out_data", out_data, RST_VAL);
      @(negedge clk);
      rst = 1'b0;

      // streaming 0x10..0x1F
      for (int i = 0; i < 16; i++) cycle(1'b1, W'(8'h10 + i), 1'b1, 1'b0);
      for (int i = 0; i < C + 1; i++) cycle(1'b0, 8'h00, 1'b1, 1'b0);
      chk("stream_latency", first_ov - first_acc, C);
      chk("stream_emit_count", emit_count, 16);
      chk("stream_occupancy", occupancy, 0);

      // backpressure with a full pipe
      for (int i = 0; i < C; i++) cycle(1'b1, W'(8'h30 + i), 1'b0, 1'b0);
      chk("bp_full", occupancy, C);
      for (int i = 0; i < 5; i++) cycle(1'b1, 8'h40, 1'b0, 1'b0);
      chk("bp_held_data", out_data, 8'h30);
      chk("bp_frozen_accepts", accept_count, 16 + C);
      for (int i = 0; i < C + 2; i++) cycle(1'b0, 8'h00, 1'b1, 1'b0);
      chk("bp_drained", emit_count, 16 + C);

      // bubbles
      max_occ = 0;
      cycle(1'b1, 8'hA1, 1'b1, 1'b0);
      cycle(1'b0, 8'hEE, 1'b1, 1'b0);
      cycle(1'b0, 8'hEE, 1'b1, 1'b0);
      cycle(1'b1, 8'hA4, 1'b1, 1'b0);
      for (int i = 0; i < C + 1; i++) cycle(1'b0, 8'h00, 1'b1, 1'b0);
      chk("bubble_max_occ_le2", (max_occ <= 2), 1);
      chk("bubble_emits", emit_count, 16 + C + 2);

      // flush with three items in flight
      for (int i = 0; i < 3; i++) cycle(1'b1, W'(8'h50 + i), 1'b1, 1'b0);
      chk("flush_occ3", occupancy, 3);
      fd_pulses = 0;
      cycle(1'b0, 8'h00, 1'b1, 1'b1);
      chk("flush_busy", busy, 1);
      done = 1'b0;
      for (int i = 0; i < 20 && !done; i++) begin
         cycle(1'b1, W'(8'hF0 + i), 1'b1, 1'b1);
         if (flush_done) done = 1'b1;
      end
      chk("flush_completes", done, 1);
      cycle(1'b0, 8'h00, 1'b1, 1'b0);
      cycle(1'b0, 8'h00, 1'b1, 1'b0);
      chk("flush_pulse_once", fd_pulses, 1);
      chk("flush_items_emitted", emit_count, 16 + C + 2 + 3);

      // empty flush
      cycle(1'b0, 8'h00, 1'b1, 1'b1);
      chk("empty_flush_busy", busy, 1);
      cycle(1'b0, 8'h00, 1'b1, 1'b0);
      chk("empty_flush_done", flush_done, 1);
      chk("empty_flush_idle", busy, 0);
      cycle(1'b0, 8'h00, 1'b1, 1'b0);

      // flush requested together with an accept
      cycle(1'b1, 8'hC1, 1'b1, 1'b1);
      done = 1'b0;
      for (int i = 0; i < 20 && !done; i++) begin
         cycle(1'b0, 8'h00, 1'b1, 1'b0);
         if (flush_done) done = 1'b1;
      end
      chk("flush_accept_completes", done, 1);
      chk("flush_accept_drained", emit_count, 16 + C + 2 + 3 + 1);

      // asynchronous reset mid-stream
      for (int i = 0; i < 3; i++) cycle(1'b1, W'(8'h60 + i), 1'b1, 1'b0);
      chk("pre_reset_occ", occupancy, 3);
      in_valid = 1'b0;
      #2 rst = 1'b1;
      #1;
      chk("areset_out_valid", out_valid, 0);
      chk("areset_occupancy", occupancy, 0);
      chk("areset_accept_count", accept_count, 0);
      chk("areset_emit_count", emit_count, 0);
      chk("areset_out_data", out_data, RST_VAL);
      model_clear();
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 2 * C; i++) cycle(1'b0, 8'h00, 1'b1, 1'b0);
      chk("post_reset_no_emit", emit_count, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/delay_stream_ctrl.md
# delay_stream_ctrl

Flow-control sequencer for a fixed-latency `delay` pipeline: converts its single `en` stall input into valid/ready handshakes on both sides. It tracks a valid bit per stage, stalls the whole pipeline under downstream backpressure, and supports a flush command that drains in-flight items. It sits between a streaming producer and consumer, driving an external `delay` instance whose `CYCLES` and `WIDTH` match its own.

## Interface
- `CYCLES`, default 4: latency of the attached delay; legal range 1..255.
- `WIDTH`, default 8: data width.
- `clk`, input, 1 bit: clock.
- `rst`, input, 1 bit: reset, asynchronous, active-high. The same `rst` also drives the attached delay instance.
- `in_valid`, input, 1 bit: upstream item present.
- `in_ready`, output, 1 bit: controller accepts the item this cycle.
- `in_data`, input, `WIDTH` bits: upstream data.
- `out_valid`, output, 1 bit: downstream item present.
- `out_ready`, input, 1 bit: downstream accepts the item.
- `out_data`, output, `WIDTH` bits: equals `delay_out`; combinational pass-through.
- `delay_en`, output, 1 bit: enable to the delay instance.
- `delay_in`, output, `WIDTH` bits: equals `in_data`; combinational.
- `delay_out`, input, `WIDTH` bits: output of the delay instance.
- `flush_req`, input, 1 bit: single-cycle request to drain the pipeline.
- `flush_done`, output, 1 bit: one-cycle pulse when the drain completes.
- `busy`, output, 1 bit: 1 while in FLUSH.
- `occupancy`, output, `$clog2(CYCLES+1)` bits: number of valid items in flight.
- `accept_count`, output, 16 bits: accepted items; wraps modulo 2^16.
- `emit_count`, output, 16 bits: emitted items; wraps modulo 2^16.

## Operation
- Valid shift register `v[CYCLES-1:0]`.
  - On a clk edge with `delay_en`=1: `v <= {v[CYCLES-2:0], in_valid && in_ready}`. For CYCLES=1, `v[0] <= in_valid && in_ready`.
  - When `delay_en`=0, `v` holds.
- `out_valid = v[CYCLES-1]`.
- `delay_en = !out_valid || out_ready`.
  - The whole pipeline stalls only when the head item is blocked.
  - Bubbles advance freely; they are not collapsed.
- `in_ready = delay_en && (state == RUN)`.
- Accept condition: `in_valid && in_ready`. Emit condition: `out_valid && out_ready`.
- `occupancy`: +1 on accept only, −1 on emit only, unchanged on both or neither. It always equals popcount(`v`).
- `accept_count` increments on each accept; `emit_count` increments on each emit.
- State machine, states RUN and FLUSH:
  - RUN → FLUSH when `flush_req`=1.
  - FLUSH → RUN on the edge where `occupancy`==0 and no emit occurs. `flush_done` is registered to 1 for exactly the following cycle.
  - A FLUSH entered with `occupancy`==0 returns to RUN on the next edge.
  - `flush_req` in FLUSH is ignored.
  - In FLUSH, `in_ready`=0 and the pipeline keeps advancing while `delay_en`=1.
- Reset values: state=RUN, `v`=0, `out_valid`=0, `occupancy`=0, `accept_count`=0, `emit_count`=0, `flush_done`=0, `busy`=0.
  - `in_ready`=1 and `delay_en`=1 during and after reset.
  - `out_data` shows the delay's RESET_VALUE.
- Reset mid-operation discards all in-flight items immediately (asynchronous). No emits occur until new items are accepted.

## Timing
- Latency: an item accepted at edge k, with `delay_en`=1 on every later edge, has `out_valid`=1 and its `out_data` stable from just after edge k+CYCLES−1. It can be consumed at edge k+CYCLES.
- Each stalled edge (`delay_en`=0) adds one cycle of latency to every in-flight item.
- Throughput is 1 item/cycle while `out_ready`=1.
- `delay_en` is combinational from `out_ready`; there is no registered path.
- `in_ready` depends combinationally on `out_ready`. Upstream must not make `in_valid` depend on `in_ready`.
- Data order is strictly FIFO; no item is duplicated or dropped.
- Simultaneous `flush_req` and accept in RUN: the accepted item counts and is drained by the flush.
- `flush_done` never coincides with `busy`=1.

## Test plan
- Reset then streaming: CYCLES=4, `out_ready`=1, `in_data`=0x10,0x11,…0x1F on consecutive cycles → `out_data`=0x10 with `out_valid` first seen at edge 4 after the first accept, then one item per cycle. `emit_count`=16, `occupancy`=0 at the end.
- Backpressure: pipeline full (`occupancy`=4), `out_ready`=0 for 5 cycles → `in_ready`=0, `delay_en`=0, `out_data` held constant, counts frozen. On release, the items drain in order.
- Bubbles: `in_valid` pattern 1,0,0,1 with data 0xA1,–,–,0xA4 → `out_valid` pattern 1,0,0,1 with the same data. `occupancy` never exceeds 2.
- Flush: `occupancy`=3, pulse `flush_req` → `busy`=1 and `in_ready`=0 until all 3 items are emitted. `flush_done` pulses exactly once, then `in_ready`=1.
- Empty flush: `flush_req` with `occupancy`=0 → `busy`=1 for one cycle, then `flush_done`=1 for one cycle.
- Async reset mid-stream with `occupancy`=3 → `out_valid`, `occupancy` and counts are 0 immediately. After release, no spurious emit occurs over 2×CYCLES cycles of `in_valid`=0.
